rx_resp_collector: RTL and testbench

Receive-side counterpart of the TX scheduler. It snoops read operations the scheduler issues on the switch memory interface and holds one outstanding read per switch. It captures each switch's read response, or declares a timeout, and pushes 32-bit response frames tagged with the original op_id into the RX FIFO. It sits between the switch read-data outputs and the RX FIFO write port.

---
 rtl/rx_resp_collector.sv | 194 +++++++++++++++++++
 tb/tb_rx_resp_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_resp_collector.sv
// Tracks one outstanding switch read per slot, captures the response or a timeout, and pushes tagged 32-bit frames.
// Latency: a response at edge k gives out_wr_en after edge k+1; a timeout-only read reaches DONE at edge k+TIMEOUT-1.
// Backpressure: out_full blocks the grant in the same cycle, and DONE slots hold their frame until they are granted.
module rx_resp_collector #(
   parameter int NUM_SW_INST = 5,
   parameter int W_WIDTH     = 8,
   parameter int FRAME_WIDTH = 32,
   parameter int TIMEOUT     = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     op_id,
   input  logic [NUM_SW_INST-1:0]         sel_en,
   input  logic [W_WIDTH-1:0]             addr,
   input  logic                           wr_rd_s,
   input  logic [NUM_SW_INST-1:0]         rsp_valid,
   input  logic [NUM_SW_INST*W_WIDTH-1:0] rsp_data,
   input  logic                           out_full,
   output logic                           out_wr_en,
   output logic [FRAME_WIDTH-1:0]         out_frame,
   output logic [NUM_SW_INST-1:0]         pend,
   output logic                           err_overrun,
   output logic                           err_unexp
);

   localparam int CW = $clog2(TIMEOUT);
   localparam int PW = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } slot_st_t;

   typedef struct packed {
      slot_st_t           st;
      logic [7:0]         op_id;
      logic [W_WIDTH-1:0] addr;
      logic [W_WIDTH-1:0] data;
      logic               to;
      logic [CW-1:0]      cnt;
   } slot_t;

   slot_t                  slot_q [NUM_SW_INST];
   slot_t                  slot_d [NUM_SW_INST];
   logic [PW-1:0]          ptr_q;
   logic [PW-1:0]          ptr_d;
   logic                   gnt_vld;
   logic [PW-1:0]          gnt_idx;
   logic [FRAME_WIDTH-1:0] gnt_frame;
   logic [NUM_SW_INST-1:0] rd_issue;
   logic                   ovr_hit;
   logic                   unexp_hit;

   assign rd_issue = sel_en & {NUM_SW_INST{~wr_rd_s}};

   // Round-robin pick: scan from ptr downwards in reverse so the first DONE slot at or after ptr wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (!out_full) begin
         for (int k = NUM_SW_INST - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SW_INST) begin
               idx = idx - NUM_SW_INST;
            end
            if (slot_q[idx].st == S_DONE) begin
               gnt_vld = 1'b1;
               gnt_idx = PW'(idx);
            end
         end
      end
   end

   // Frame for the granted slot and the pointer value that follows it.
   always_comb begin
      gnt_frame = {slot_q[gnt_idx].op_id, slot_q[gnt_idx].addr, slot_q[gnt_idx].data,
                   4'(gnt_idx), 3'b000, slot_q[gnt_idx].to};
      ptr_d     = (gnt_idx == PW'(NUM_SW_INST - 1)) ? '0 : gnt_idx + PW'(1);
   end

   // Per-slot next state: issue capture, response/timeout completion, release on grant, error detection.
   always_comb begin
      ovr_hit   = 1'b0;
      unexp_hit = 1'b0;
      for (int i = 0; i < NUM_SW_INST; i++) begin
         slot_d[i] = slot_q[i];
         case (slot_q[i].st)
            S_IDLE: begin
               // A response landing with the issue belongs to nobody; the slot still arms.
               if (rsp_valid[i]) begin
                  unexp_hit = 1'b1;
               end
               if (rd_issue[i]) begin
                  slot_d[i].st    = S_WAIT;
                  slot_d[i].op_id = op_id;
                  slot_d[i].addr  = addr;
                  slot_d[i].data  = '0;
                  slot_d[i].to    = 1'b0;
                  slot_d[i].cnt   = '0;
               end
            end
            S_WAIT: begin
               if (rd_issue[i]) begin
                  ovr_hit = 1'b1;
               end
               // The response takes priority over a timeout expiring in the same cycle.
               if (rsp_valid[i]) begin
                  slot_d[i].st   = S_DONE;
                  slot_d[i].data = rsp_data[i*W_WIDTH +: W_WIDTH];
                  slot_d[i].to   = 1'b0;
               end else if (slot_q[i].cnt == CW'(TIMEOUT - 2)) begin
                  slot_d[i].st   = S_DONE;
                  slot_d[i].data = '0;
                  slot_d[i].to   = 1'b1;
                  slot_d[i].cnt  = slot_q[i].cnt + CW'(1);
               end else begin
                  slot_d[i].cnt  = slot_q[i].cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (rd_issue[i]) begin
                  ovr_hit = 1'b1;
               end
               if (rsp_valid[i]) begin
                  unexp_hit = 1'b1;
               end
               if (gnt_vld && (gnt_idx == PW'(i))) begin
                  slot_d[i].st = S_IDLE;
               end
            end
            default: begin
               slot_d[i].st = S_IDLE;
            end
         endcase
      end
   end

   // Slot state and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SW_INST; i++) begin
            slot_q[i] <= '0;
         end
         ptr_q <= '0;
      end else begin
         for (int i = 0; i < NUM_SW_INST; i++) begin
            slot_q[i] <= slot_d[i];
         end
         if (gnt_vld) begin
            ptr_q <= ptr_d;
         end
      end
   end

   // Registered FIFO push; the frame holds between pushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_wr_en <= 1'b0;
         out_frame <= '0;
      end else begin
         out_wr_en <= gnt_vld;
         if (gnt_vld) begin
            out_frame <= gnt_frame;
         end
      end
   end

   // Sticky protocol error flags, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overrun <= 1'b0;
         err_unexp   <= 1'b0;
      end else begin
         if (ovr_hit) begin
            err_overrun <= 1'b1;
         end
         if (unexp_hit) begin
            err_unexp <= 1'b1;
         end
      end
   end

   // A slot is pending whenever it is not idle.
   always_comb begin
      pend = '0;
      for (int i = 0; i < NUM_SW_INST; i++) begin
         pend[i] = (slot_q[i].st != S_IDLE);
      end
   end

endmodule

// File: tb/tb_rx_resp_collector.sv
// Randomized and directed bench for rx_resp_collector against a deadline-based reference model.
// Latency: the model predicts registered outputs edge by edge and compares them 1 time unit after each rising edge.
// Backpressure: out_full is driven both in directed round-robin scenarios and at random.
module tb_rx_resp_collector;

   localparam int NSW = 5;
   localparam int TO  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       op_id;
   logic [NSW-1:0]   sel_en;
   logic [7:0]       addr;
   logic             wr_rd_s;
   logic [NSW-1:0]   rsp_valid;
   logic [NSW*8-1:0] rsp_data;
   logic             out_full;
   logic             out_wr_en;
   logic [31:0]      out_frame;
   logic [NSW-1:0]   pend;
   logic             err_overrun;
   logic             err_unexp;

   rx_resp_collector #(
      .NUM_SW_INST (NSW),
      .W_WIDTH     (8),
      .FRAME_WIDTH (32),
      .TIMEOUT     (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op_id       (op_id),
      .sel_en      (sel_en),
      .addr        (addr),
      .wr_rd_s     (wr_rd_s),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .out_full    (out_full),
      .out_wr_en   (out_wr_en),
      .out_frame   (out_frame),
      .pend        (pend),
      .err_overrun (err_overrun),
      .err_unexp   (err_unexp)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: each read carries an absolute completion deadline instead of a counter.
   bit          m_wait     [NSW];
   bit          m_ready    [NSW];
   logic [7:0]  m_op       [NSW];
   logic [7:0]  m_addr     [NSW];
   logic [7:0]  m_data     [NSW];
   bit          m_to       [NSW];
   int          m_deadline [NSW];
   int          m_ptr;
   bit          m_wr_en;
   logic [31:0] m_frame;
   bit          m_ovr;
   bit          m_unexp;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSW; i++) begin
         m_wait[i]  = 1'b0;
         m_ready[i] = 1'b0;
         m_op[i]    = '0;
         m_addr[i]  = '0;
         m_data[i]  = '0;
         m_to[i]    = 1'b0;
         m_deadline[i] = 0;
      end
      m_ptr   = 0;
      m_wr_en = 1'b0;
      m_frame = '0;
      m_ovr   = 1'b0;
      m_unexp = 1'b0;
   endtask

   task automatic model_edge();
      int          g;
      logic [31:0] f;
      g = -1;
      f = '0;
      if (!out_full) begin
         for (int k = 0; k < NSW; k++) begin
            int j;
            j = (m_ptr + k) % NSW;
            if (g < 0 && m_ready[j]) g = j;
         end
      end
      if (g >= 0) f = {m_op[g], m_addr[g], m_data[g], 4'(g), 3'b000, m_to[g]};
      for (int i = 0; i < NSW; i++) begin
         bit iss;
         iss = sel_en[i] && !wr_rd_s;
         if (m_ready[i]) begin
            if (iss) m_ovr = 1'b1;
            if (rsp_valid[i]) m_unexp = 1'b1;
            if (i == g) m_ready[i] = 1'b0;
         end else if (m_wait[i]) begin
            if (iss) m_ovr = 1'b1;
            if (rsp_valid[i]) begin
               m_wait[i] = 1'b0; m_ready[i] = 1'b1;
               m_data[i] = rsp_data[i*8 +: 8]; m_to[i] = 1'b0;
            end else if (cyc == m_deadline[i]) begin
               m_wait[i] = 1'b0; m_ready[i] = 1'b1;
               m_data[i] = 8'h00; m_to[i] = 1'b1;
            end
         end else begin
            if (rsp_valid[i]) m_unexp = 1'b1;
            if (iss) begin
               m_wait[i] = 1'b1;
               m_op[i]   = op_id;
               m_addr[i] = addr;
               m_deadline[i] = cyc + TO - 1;
            end
         end
      end
      if (g >= 0) begin
         m_wr_en = 1'b1;
         m_frame = f;
         m_ptr   = (g + 1) % NSW;
      end else begin
         m_wr_en = 1'b0;
      end
      cyc++;
   endtask

   task automatic compare_all(string tag);
      logic [NSW-1:0] ep;
      ep = '0;
      for (int i = 0; i < NSW; i++) ep[i] = m_wait[i] | m_ready[i];
      chk({tag, "_wr_en"}, 32'(out_wr_en), 32'(m_wr_en));
      chk({tag, "_frame"}, out_frame, m_frame);
      chk({tag, "_pend"}, 32'(pend), 32'(ep));
      chk({tag, "_ovr"}, 32'(err_overrun), 32'(m_ovr));
      chk({tag, "_unexp"}, 32'(err_unexp), 32'(m_unexp));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all("cyc");
   endtask

   task automatic steps(int n);
      repeat (n) step();
   endtask

   task automatic idle_in();
      sel_en    = '0;
      wr_rd_s   = 1'b0;
      rsp_valid = '0;
      op_id     = '0;
      addr      = '0;
   endtask

   task automatic issue(int sw, logic [7:0] id, logic [7:0] ad);
      idle_in();
      sel_en[sw] = 1'b1;
      op_id = id;
      addr  = ad;
      step();
      idle_in();
   endtask

   task automatic respond(int sw, logic [7:0] d);
      idle_in();
      rsp_valid[sw] = 1'b1;
      rsp_data[sw*8 +: 8] = d;
      step();
      idle_in();
   endtask

   task automatic mid_reset();
      idle_in();
      rst_n = 1'b0;
      #2;
      model_reset();
      compare_all("rst");
      rst_n = 1'b1;
   endtask

   // Slots 0, 1, 3 complete under back-pressure, then drain in the given order.
   task automatic rr_scenario(int o0, int o1, int o2);
      out_full = 1'b1;
      issue(0, 8'hA0, 8'h10);
      issue(1, 8'hA1, 8'h11);
      issue(3, 8'hA3, 8'h13);
      idle_in();
      rsp_valid = 5'b01011;
      rsp_data  = {8'h00, 8'hD3, 8'h00, 8'hD1, 8'hD0};
      step();
      idle_in();
      steps(2);
      chk("rr_held_wr_en", 32'(out_wr_en), 32'd0);
      out_full = 1'b0;
      step(); chk("rr_first",  32'(out_frame[7:4]), 32'(o0));
      step(); chk("rr_second", 32'(out_frame[7:4]), 32'(o1));
      step(); chk("rr_third",  32'(out_frame[7:4]), 32'(o2));
      step(); chk("rr_idle_wr_en", 32'(out_wr_en), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      out_full = 1'b0;
      rsp_data = '0;
      idle_in();
      model_reset();
      #12;
      compare_all("reset");
      chk("reset_frame", out_frame, 32'h0);
      rst_n = 1'b1;
      steps(2);

      // Single read: response three cycles after issue, frame two edges later.
      issue(2, 8'h11, 8'h40);
      steps(2);
      respond(2, 8'hA5);
      step();
      chk("single_wr_en", 32'(out_wr_en), 32'd1);
      chk("single_frame", out_frame, 32'h1140A520);
      chk("single_pend", 32'(pend), 32'd0);
      step();
      chk("single_pulse", 32'(out_wr_en), 32'd0);

      // Timeout on switch 0.
      issue(0, 8'h22, 8'h05);
      steps(7);
      chk("to_pend", 32'(pend), 32'd1);
      step();
      chk("to_wr_en", 32'(out_wr_en), 32'd1);
      chk("to_frame", out_frame, 32'h22050001);

      // Round robin from ptr=0, then from ptr=2.
      mid_reset();
      rr_scenario(0, 1, 3);
      issue(1, 8'h55, 8'h01);
      respond(1, 8'h0F);
      steps(2);
      rr_scenario(3, 0, 1);

      // Overrun on busy switch 4 and unexpected response on idle switch 1.
      issue(4, 8'h33, 8'h01);
      idle_in();
      sel_en[4] = 1'b1;
      op_id = 8'h44;
      rsp_valid[1] = 1'b1;
      step();
      idle_in();
      chk("err_overrun", 32'(err_overrun), 32'd1);
      chk("err_unexp", 32'(err_unexp), 32'd1);
      respond(4, 8'hC3);
      step();
      chk("ovr_keep_op", 32'(out_frame[31:24]), 32'h33);

      // Writes are ignored; multi-select read; reset drops pending slots.
      mid_reset();
      idle_in();
      sel_en[2] = 1'b1;
      wr_rd_s   = 1'b1;
      step();
      idle_in();
      steps(3);
      chk("write_pend", 32'(pend), 32'd0);
      chk("write_wr_en", 32'(out_wr_en), 32'd0);
      idle_in();
      sel_en = 5'b01001;
      op_id  = 8'h77;
      step();
      idle_in();
      step();
      chk("multi_pend", 32'(pend), 32'h09);
      mid_reset();
      steps(10);
      chk("post_rst_wr_en", 32'(out_wr_en), 32'd0);
      chk("post_rst_pend", 32'(pend), 32'd0);

      // Response on the exact timeout edge wins.
      issue(2, 8'h66, 8'h77);
      steps(6);
      respond(2, 8'h5A);
      step();
      chk("edge_frame", out_frame, 32'h66775A20);

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         int r;
         idle_in();
         r = $urandom_range(0, 9);
         if (r < 3) sel_en = NSW'(1) << $urandom_range(0, NSW - 1);
         else if (r == 3) sel_en = NSW'($urandom);
         wr_rd_s = ($urandom_range(0, 3) == 0);
         op_id   = 8'($urandom);
         addr    = 8'($urandom);
         for (int i = 0; i < NSW; i++) begin
            rsp_data[i*8 +: 8] = 8'($urandom);
            if (m_wait[i] && $urandom_range(0, 5) == 0) rsp_valid[i] = 1'b1;
            else if ($urandom_range(0, 40) == 0) rsp_valid[i] = 1'b1;
         end
         out_full = ($urandom_range(0, 3) == 0);
         step();
         if ($urandom_range(0, 399) == 0) mid_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
